// File: rtl/es_div_ctrl.sv
// es_div_ctrl: multi-cycle integer divide controller for the EX stage.
// Runs a 32-step restoring divider, one quotient bit per cycle, holds the
// fixed-up quotient or remainder until EX hands the instruction to MEM,
// and supplies the EX ready-go term so the pipeline stalls meanwhile.
module es_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic        div_signed,
  input  logic        div_unsigned,
  input  logic        div_mod,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        es_go,
  input  logic        div_cancel,
  output logic        div_ready_go,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // The partial remainder is always smaller than the divisor, so its top bit
  // of the 33-bit working value is always zero and is not stored.
  logic [31:0] prem;
  logic [31:0] dq;
  logic [31:0] dsr;
  logic [31:0] src1_raw;
  logic        q_neg;
  logic        r_neg;
  logic        mod_sel;
  logic        dz;
  logic [5:0]  cnt;

  logic        div_req;
  logic        start;
  logic        last_step;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] prem_next;
  logic [31:0] q_next;
  logic [31:0] final_q;
  logic [31:0] final_r;
  logic [31:0] final_res;

  assign div_req      = es_valid & (div_signed | div_unsigned);
  assign start        = div_req & ~div_cancel & (state == IDLE);
  assign last_step    = (cnt == 6'd31);
  assign div_busy     = (state == BUSY);
  assign div_done     = (state == DONE);
  assign div_ready_go = ~div_req | div_done;

  // Operand magnitudes, one restoring step, and the sign/zero fix-up of the final result
  always_comb begin
    abs1      = src1;
    abs2      = src2;
    if (div_signed && src1[31]) abs1 = -src1;
    if (div_signed && src2[31]) abs2 = -src2;

    shifted   = {1'b0, prem, dq[31]};
    trial     = shifted - {1'b0, dsr};
    if (!trial[32]) begin
      prem_next = trial[31:0];
      q_next    = {dq[30:0], 1'b1};
    end else begin
      prem_next = shifted[31:0];
      q_next    = {dq[30:0], 1'b0};
    end

    final_q   = q_neg ? -q_next : q_next;
    final_r   = r_neg ? -prem_next : prem_next;
    if (dz) begin
      final_q = 32'hFFFF_FFFF;
      final_r = src1_raw;
    end
    final_res = mod_sel ? final_q : final_r;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a cancel from any state wins over everything else
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (es_go)     state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (div_cancel) state_nxt = IDLE;
  end

  // Operand capture in IDLE, iteration in BUSY, result registered on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prem       <= 32'd0;
      dq         <= 32'd0;
      dsr        <= 32'd0;
      src1_raw   <= 32'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      mod_sel    <= 1'b0;
      dz         <= 1'b0;
      cnt        <= 6'd0;
      div_result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prem     <= 32'd0;
            dq       <= abs1;
            dsr      <= abs2;
            src1_raw <= src1;
            q_neg    <= div_signed & (src1[31] ^ src2[31]);
            r_neg    <= div_signed & src1[31];
            mod_sel  <= div_mod;
            dz       <= (src2 == 32'd0);
            cnt      <= 6'd0;
          end
        end
        BUSY: begin
          prem <= prem_next;
          dq   <= q_next;
          cnt  <= cnt + 6'd1;
          if (last_step && !div_cancel) div_result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/es_div_ctrl.md
# es_div_ctrl

Multi-cycle integer divide controller for the execute stage. It latches operands when a div.w/mod.w/div.wu/mod.wu instruction is valid in EX and runs a 32-iteration restoring divider, one quotient bit per cycle. It holds the result until EX hands the instruction to MEM, and it supplies the EX-stage ready-go term so the pipeline stalls for the duration of the divide.

## Interface

- No parameters; the data width is fixed at 32.
- `clk` in 1: the single clock for the block.
- `reset` in 1: asynchronous, active-high.
- `es_valid` in 1: EX holds a valid instruction.
- `div_signed` in 1: decoded div.w / mod.w.
- `div_unsigned` in 1: decoded div.wu / mod.wu.
- `div_mod` in 1: 1 selects the quotient (div.w / div.wu), 0 selects the remainder (mod.w / mod.wu). This is the same encoding the decode stage places on the bus.
- `src1` in 32: dividend (rj value).
- `src2` in 32: divisor (rk value).
- `es_go` in 1: EX instruction advances this cycle, i.e. `es_ready_go && ms_allowin`.
- `div_cancel` in 1: the EX instruction is flushed; abort the current operation.
- `div_ready_go` out 1: EX ready-go contribution for divide instructions.
- `div_busy` out 1: the iteration engine is running.
- `div_done` out 1: `div_result` is valid.
- `div_result` out 32: quotient or remainder, as selected by `div_mod`.

## Operation

- `div_req = es_valid & (div_signed | div_unsigned)`.
- `div_ready_go = ~div_req | div_done`.
- **IDLE**
  - On `div_req & ~div_cancel`, go to BUSY.
  - Latch absolute values `|src1|` and `|src2|`. Absolute value applies only when signed; unsigned operands pass through raw.
  - Latch the quotient sign `q_neg = signed & (src1[31]^src2[31])` and the remainder sign `r_neg = signed & src1[31]`.
  - Latch the `div_mod` selection and a divide-by-zero flag `dz = (src2 == 0)`.
  - Clear the 33-bit partial remainder and the 6-bit counter.
- **BUSY**, one step per cycle:
  - `trial = {prem[31:0], dq[31]} - {1'b0, dsr}`, computed at 33 bits.
  - If `trial[32] == 0`: `prem <= trial`, shift 1 into the quotient.
  - Otherwise: `prem <= {prem[31:0], dq[31]}`, shift 0 into the quotient.
  - Shift the dividend and quotient register left each step.
  - Counter runs 0..31; when the step with counter == 31 completes, go to DONE.
- **DONE**
  - Result is `q_neg ? -q : q` or `r_neg ? -r : r`, registered on entry to DONE and held constant.
  - `div_done = 1`.
  - On `es_go`, go to IDLE.
- `div_cancel` in any state: go to IDLE next cycle with `div_done = 0`; no result is produced.
- Divide by zero, signed or unsigned: quotient = 32'hFFFFFFFF, remainder = `src1` unmodified. This is forced from `dz` and overrides the sign fix-up.
- Signed overflow (`0x80000000 / 0xFFFFFFFF`): quotient = 32'h80000000, remainder = 0, which is the natural result of 32-bit truncation.
- Operands are sampled only in IDLE. Changes on `src1`/`src2` during BUSY or DONE are ignored.
- Non-divide instructions never leave IDLE.

## Timing

- Reset values: state IDLE, `div_busy = 0`, `div_done = 0`, `div_result = 0`, counter 0, all datapath registers 0.
- Call the first cycle in which `div_req` is seen in IDLE cycle 0.
  - `div_busy = 1` in cycles 1..32.
  - `div_done = 1` and `div_result` valid from cycle 33.
  - EX stalls for 33 cycles minimum.
- `div_done` stays high, with the result stable, until the cycle in which `es_go = 1`; the following cycle is IDLE.
- Back-to-back divides:
  - A new divide instruction arriving in EX in the cycle after `es_go` is accepted in that cycle.
  - There is no re-trigger on the departing instruction, because `div_done` gates `div_ready_go` and the state leaves DONE on the same edge.
- Cancel and `es_go` in the same cycle: cancel wins; go to IDLE.
- Asynchronous `reset` mid-BUSY: all outputs clear immediately. After release, the block waits for a fresh `div_req`.
- `div_ready_go` is combinational from `es_valid`, the decode bits and `div_done`. There is no other combinational input→output path.

## Test plan

- div.wu: 100 / 7 -> `div_done` rises at cycle 33, result 14; for mod.wu, result 2. `div_ready_go = 0` during cycles 0..32.
- div.w: -7 / 2 -> 0xFFFFFFFD; mod.w -> 0xFFFFFFFF; div.w 7 / -2 -> 0xFFFFFFFD; mod.w 7 / -2 -> 1.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Divide by zero, 0x1234 / 0, both signednesses -> quotient 0xFFFFFFFF, remainder 0x1234.
- Hold `es_go = 0` for 5 cycles in DONE -> result and `div_done` stable throughout. Then `es_go` is pulsed and a second divide (0xFFFFFFFF / 0x10, unsigned) is presented the next cycle -> result 0x0FFFFFFF at its own cycle 33.
- `div_cancel` asserted at cycle 10 of BUSY -> IDLE next cycle with `div_done` never asserted. A following 9 / 3 yields 3, with no stale data.
- Async `reset` asserted mid-BUSY, between clock edges -> `div_busy` and `div_done` drop immediately. Non-divide instructions (`div_signed = div_unsigned = 0`) -> `div_ready_go = 1` and the state stays IDLE.
